// File: rtl/mp64_extmem_arb_if.sv
`timescale 1ns/1ps
// Per-master command/data channel between a bus master and the external-memory arbiter.
//
// Handshake: the master raises req with addr/wen/burst_len stable and holds them
// until ack (a one-cycle pulse in the cycle the PHY accepts the command). After
// ack the fields may change. Write beats: wdata presents the current beat; wnext
// pulses in the cycle that beat is consumed, and the master advances wdata on
// the following clock edge. Read beats arrive as rdata qualified by rvalid (no
// back-pressure). done pulses once per accepted command, together with the last
// beat, or alone with err on a watchdog abort. req still high after done is a
// new request.
interface mp64_extmem_arb_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
);
    logic              req;
    logic [ADDR_W-1:0] addr;
    logic              wen;
    logic [3:0]        burst_len;
    logic [DATA_W-1:0] wdata;
    logic              ack;
    logic              wnext;
    logic [DATA_W-1:0] rdata;
    logic              rvalid;
    logic              done;
    logic              err;

    modport master (
        output req, addr, wen, burst_len, wdata,
        input  ack, wnext, rdata, rvalid, done, err
    );

    modport slave (
        input  req, addr, wen, burst_len, wdata,
        output ack, wnext, rdata, rvalid, done, err
    );
endinterface

// File: rtl/mp64_extmem_arb.sv
`timescale 1ns/1ps
// Two-master round-robin arbiter/sequencer for the external-memory PHY port.
// One transaction outstanding at a time: grant in IDLE, issue command, then
// route read beats or pace write beats, with a watchdog abort.
module mp64_extmem_arb #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 64,
    parameter int WR_LAT  = 2,     // must be >= 1
    parameter int TIMEOUT = 1024
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    mp64_extmem_arb_if.slave  m0_if,
    mp64_extmem_arb_if.slave  m1_if,
    output logic              phy_req_o,
    output logic [ADDR_W-1:0] phy_addr_o,
    output logic              phy_wen_o,
    output logic [DATA_W-1:0] phy_wdata_o,
    output logic [3:0]        phy_burst_len_o,
    input  logic [DATA_W-1:0] phy_rdata_i,
    input  logic              phy_rvalid_i,
    input  logic              phy_ready_i,
    output logic [1:0]        dbg_state_o
);
    typedef enum logic [1:0] {S_IDLE, S_CMD, S_RD, S_WR} state_t;

    localparam int WD_W  = $clog2(TIMEOUT + 1);
    localparam int LAT_W = $clog2(WR_LAT + 1);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);
    localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(WR_LAT - 1);

    state_t            state_q, state_d;
    logic              gnt_q, gnt_d;     // granted master; doubles as last_grant
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wen_q, wen_d;
    logic [3:0]        len_q, len_d;
    logic [3:0]        beat_q, beat_d;
    logic [WD_W-1:0]   wd_q, wd_d;       // cycles since grant/accept/last beat
    logic [LAT_W-1:0]  lat_q, lat_d;     // cycles left before write beat 0

    logic ack, wnext, rvalid, done, err, pick1;
    logic rd_beat, wr_beat, last_beat, wd_expired;

    assign rd_beat    = (state_q == S_RD) && phy_rvalid_i;
    assign wr_beat    = (state_q == S_WR) && (lat_q == '0);
    assign last_beat  = (rd_beat || wr_beat) && (beat_q == len_q);
    assign wd_expired = (wd_q == WD_LAST);

    // State and datapath registers; reset drops any transaction in flight.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= S_IDLE;
            gnt_q   <= 1'b1;
            addr_q  <= '0;
            wen_q   <= 1'b0;
            len_q   <= '0;
            beat_q  <= '0;
            wd_q    <= '0;
            lat_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            addr_q  <= addr_d;
            wen_q   <= wen_d;
            len_q   <= len_d;
            beat_q  <= beat_d;
            wd_q    <= wd_d;
            lat_q   <= lat_d;
        end
    end

    // Next-state, grant selection, beat counting, watchdog and strobe generation.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        addr_d  = addr_q;
        wen_d   = wen_q;
        len_d   = len_q;
        beat_d  = beat_q;
        wd_d    = wd_q;
        lat_d   = lat_q;
        ack     = 1'b0;
        wnext   = 1'b0;
        rvalid  = 1'b0;
        done    = 1'b0;
        err     = 1'b0;
        pick1   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (phy_ready_i && (m0_if.req || m1_if.req)) begin
                    // On a tie the master that did not win last time goes next.
                    pick1   = (m0_if.req && m1_if.req) ? ~gnt_q : m1_if.req;
                    gnt_d   = pick1;
                    addr_d  = pick1 ? m1_if.addr      : m0_if.addr;
                    wen_d   = pick1 ? m1_if.wen       : m0_if.wen;
                    len_d   = pick1 ? m1_if.burst_len : m0_if.burst_len;
                    wd_d    = '0;
                    state_d = S_CMD;
                end
            end
            S_CMD: begin
                if (phy_ready_i) begin
                    ack     = 1'b1;
                    beat_d  = '0;
                    wd_d    = '0;
                    lat_d   = LAT_INIT;
                    state_d = wen_q ? S_WR : S_RD;
                end else if (wd_expired) begin
                    done    = 1'b1;
                    err     = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            S_RD, S_WR: begin
                if (rd_beat || wr_beat) begin
                    rvalid = rd_beat;
                    wnext  = wr_beat;
                    beat_d = beat_q + 1'b1;
                    wd_d   = '0;
                    if (last_beat) begin
                        done    = 1'b1;
                        state_d = S_IDLE;
                    end
                end else if (wd_expired) begin
                    done    = 1'b1;
                    err     = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    wd_d = wd_q + 1'b1;
                    if (state_q == S_WR) lat_d = lat_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign phy_req_o       = (state_q == S_CMD);
    assign phy_addr_o      = addr_q;
    assign phy_wen_o       = wen_q;
    assign phy_burst_len_o = len_q;
    assign phy_wdata_o     = (state_q != S_WR) ? '0 : (gnt_q ? m1_if.wdata : m0_if.wdata);
    assign dbg_state_o     = state_q;

    assign m0_if.ack    = ack    & ~gnt_q;
    assign m0_if.wnext  = wnext  & ~gnt_q;
    assign m0_if.rvalid = rvalid & ~gnt_q;
    assign m0_if.done   = done   & ~gnt_q;
    assign m0_if.err    = err    & ~gnt_q;
    assign m0_if.rdata  = (rvalid & ~gnt_q) ? phy_rdata_i : '0;

    assign m1_if.ack    = ack    & gnt_q;
    assign m1_if.wnext  = wnext  & gnt_q;
    assign m1_if.rvalid = rvalid & gnt_q;
    assign m1_if.done   = done   & gnt_q;
    assign m1_if.err    = err    & gnt_q;
    assign m1_if.rdata  = (rvalid & gnt_q) ? phy_rdata_i : '0;
endmodule

// File: tb/tb_mp64_extmem_arb.sv
`timescale 1ns/1ps
// Bench for mp64_extmem_arb: PHY memory model, two master drivers, scoreboard.
module tb_mp64_extmem_arb;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 64;
    localparam int WR_LAT  = 2;
    localparam int TIMEOUT = 64;

    // ---------------- clock / reset ----------------
    logic sys_clk   = 1'b0;
    logic sys_rst_n = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // ---------------- DUT ----------------
    mp64_extmem_arb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m0_if ();
    mp64_extmem_arb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m1_if ();

    logic              phy_req, phy_wen;
    logic [ADDR_W-1:0] phy_addr;
    logic [DATA_W-1:0] phy_wdata;
    logic [3:0]        phy_burst_len;
    logic [DATA_W-1:0] phy_rdata  = '0;
    logic              phy_rvalid = 1'b0;
    logic              phy_ready  = 1'b0;
    logic [1:0]        dbg_state;

    mp64_extmem_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WR_LAT(WR_LAT), .TIMEOUT(TIMEOUT)) dut (
        .sys_clk         (sys_clk),
        .sys_rst_n       (sys_rst_n),
        .m0_if           (m0_if),
        .m1_if           (m1_if),
        .phy_req_o       (phy_req),
        .phy_addr_o      (phy_addr),
        .phy_wen_o       (phy_wen),
        .phy_wdata_o     (phy_wdata),
        .phy_burst_len_o (phy_burst_len),
        .phy_rdata_i     (phy_rdata),
        .phy_rvalid_i    (phy_rvalid),
        .phy_ready_i     (phy_ready),
        .dbg_state_o     (dbg_state)
    );

    // master-side drive and observe arrays, index = master number
    logic              req_r[2];
    logic [ADDR_W-1:0] addr_r[2];
    logic              wen_r[2];
    logic [3:0]        len_r[2];
    logic [DATA_W-1:0] wdata_r[2];
    logic [1:0]        ack_w, wnext_w, rvalid_w, done_w, err_w;
    logic [DATA_W-1:0] rdata_w[2];

    assign m0_if.req = req_r[0];  assign m0_if.addr = addr_r[0];  assign m0_if.wen = wen_r[0];
    assign m0_if.burst_len = len_r[0];  assign m0_if.wdata = wdata_r[0];
    assign m1_if.req = req_r[1];  assign m1_if.addr = addr_r[1];  assign m1_if.wen = wen_r[1];
    assign m1_if.burst_len = len_r[1];  assign m1_if.wdata = wdata_r[1];
    assign ack_w    = {m1_if.ack,    m0_if.ack};
    assign wnext_w  = {m1_if.wnext,  m0_if.wnext};
    assign rvalid_w = {m1_if.rvalid, m0_if.rvalid};
    assign done_w   = {m1_if.done,   m0_if.done};
    assign err_w    = {m1_if.err,    m0_if.err};
    assign rdata_w[0] = m0_if.rdata;
    assign rdata_w[1] = m1_if.rdata;

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- memories ----------------
    logic [63:0] ext_mem[int];   // PHY-side storage, written only through the DUT
    logic [63:0] ref_mem[int];   // bench's view of what memory should hold

    function automatic logic [63:0] init_val(input int w);
        return {32'hC0DE_0000 ^ 32'(w), 32'(w) * 32'h9E37_79B9};
    endfunction
    function automatic logic [63:0] ext_rd(input int w);
        return ext_mem.exists(w) ? ext_mem[w] : init_val(w);
    endfunction
    function automatic logic [63:0] ref_rd(input int w);
        return ref_mem.exists(w) ? ref_mem[w] : init_val(w);
    endfunction

    // ---------------- PHY model ----------------
    logic [63:0] rd_q[$];
    bit withhold = 0;
    bit spur_en  = 0;
    bit wr_act   = 0;
    int wr_phase, wr_word, wr_len;

    always @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            rd_q.delete();
            wr_act = 0;
        end else begin
            if (wr_act) begin
                wr_phase++;
                if (wr_phase >= WR_LAT) begin
                    ext_mem[wr_word + wr_phase - WR_LAT] = phy_wdata;
                    if (wr_phase - WR_LAT == wr_len) wr_act = 0;
                end
            end
            if (phy_req && phy_ready) begin
                if (phy_wen) begin
                    wr_act = 1; wr_phase = 0;
                    wr_word = int'(phy_addr >> 3); wr_len = int'(phy_burst_len);
                end else begin
                    for (int i = 0; i <= int'(phy_burst_len); i++)
                        rd_q.push_back(ext_rd(int'(phy_addr >> 3) + i));
                end
            end
        end
        #1;
        phy_ready = ($urandom_range(0, 3) != 0);
        if (sys_rst_n && !withhold && rd_q.size() > 0 && $urandom_range(0, 3) != 0) begin
            phy_rvalid = 1'b1;
            phy_rdata  = rd_q.pop_front();
        end else if (spur_en && rd_q.size() == 0 && $urandom_range(0, 5) == 0) begin
            phy_rvalid = 1'b1;
            phy_rdata  = {$urandom, $urandom};
        end else begin
            phy_rvalid = 1'b0;
            phy_rdata  = '0;
        end
    end

    // ---------------- scoreboard ----------------
    bit          mon_en = 0;
    bit          busy   = 0;
    bit          act_wen;
    int          act_m, act_len, beats, cyc, idle;
    logic [63:0] exp_q[$];
    int          ack_log[$];
    int          wait_cnt[2];
    int          ack_cnt[2];
    int          done_cnt[2];
    int          err_cnt[2];
    logic [63:0] last_rdata[2];

    always @(negedge sys_clk) begin
        if (mon_en && sys_rst_n) begin
            if (busy) begin cyc++; idle++; end
            for (int m = 0; m < 2; m++) begin
                int o;
                o = 1 - m;
                if (ack_w[m]) begin
                    check("ack_while_busy", 64'(busy), 0);
                    check("cmd_addr", phy_addr, addr_r[m]);
                    check("cmd_wen", 64'(phy_wen), 64'(wen_r[m]));
                    check("cmd_len", 64'(phy_burst_len), 64'(len_r[m]));
                    check("rr_wait", 64'(req_r[o] && wait_cnt[o] >= 1), 0);
                    if (req_r[o]) wait_cnt[o]++;
                    wait_cnt[m] = 0;
                    busy = 1; act_m = m; act_wen = wen_r[m]; act_len = int'(len_r[m]);
                    beats = 0; cyc = 0; idle = 0;
                    ack_log.push_back(m);
                    ack_cnt[m]++;
                    exp_q.delete();
                    if (!wen_r[m])
                        for (int i = 0; i <= act_len; i++)
                            exp_q.push_back(ref_rd(int'(addr_r[m] >> 3) + i));
                end else if (!(busy && act_m == m)) begin
                    check("quiet", {59'd0, wnext_w[m], rvalid_w[m], done_w[m], err_w[m], |rdata_w[m]}, 0);
                end
            end
            if (busy) begin
                if (rvalid_w[act_m]) begin
                    check("rvalid_on_read", 64'(act_wen), 0);
                    check("rd_beat_expected", 64'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) check("rdata", rdata_w[act_m], exp_q.pop_front());
                    last_rdata[act_m] = rdata_w[act_m];
                    beats++; idle = 0;
                end
                if (wnext_w[act_m]) begin
                    check("wnext_on_write", 64'(act_wen), 1);
                    check("wnext_time", 64'(cyc), 64'(WR_LAT + beats));
                    beats++; idle = 0;
                end
                if (done_w[act_m]) begin
                    if (err_w[act_m]) begin
                        check("tmo_cycles", 64'(idle), 64'(TIMEOUT));
                        err_cnt[act_m]++;
                    end else begin
                        check("done_beats", 64'(beats), 64'(act_len + 1));
                    end
                    done_cnt[act_m]++;
                    busy = 0;
                    exp_q.delete();
                end else if (err_w[act_m]) begin
                    check("err_with_done", 64'(done_w[act_m]), 1);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        if (n > 0) begin
            repeat (n) @(posedge sys_clk);
            #1;
        end
    endtask

    // Runs one transaction for master m; call at posedge+1.
    task automatic run_txn(input int m, input logic [31:0] a, input logic w,
                           input logic [3:0] l, input logic [63:0] base);
        int  n;
        bit  got, wn, errd;
        int  bi;
        addr_r[m] = a; wen_r[m] = w; len_r[m] = l; wdata_r[m] = base; req_r[m] = 1'b1;
        got = 0; n = 0;
        while (!got && n < 3000) begin
            @(negedge sys_clk);
            if (ack_w[m]) got = 1;
            n++;
        end
        check("ack_seen", 64'(got), 1);
        @(posedge sys_clk); #1;
        req_r[m] = 1'b0;
        if (!got) return;
        got = 0; n = 0; bi = 0; errd = 0;
        while (!got && n < 3000) begin
            @(negedge sys_clk);
            wn = wnext_w[m];
            if (done_w[m]) begin got = 1; errd = err_w[m]; end
            @(posedge sys_clk); #1;
            if (wn) begin bi++; wdata_r[m] = base + 64'(bi); end
            n++;
        end
        check("done_seen", 64'(got), 1);
        if (w && got && !errd) begin
            for (int i = 0; i <= int'(l); i++) begin
                check("wr_mem", ext_rd(int'(a >> 3) + i), base + 64'(i));
                ref_mem[int'(a >> 3) + i] = base + 64'(i);
            end
        end
    endtask

    function automatic logic [31:0] rnd_addr();
        return 32'($urandom_range(0, 63)) << 3;
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        int          snap_a, snap_d, snap_e, n;
        logic [63:0] d;
        for (int m = 0; m < 2; m++) begin
            req_r[m] = 0; addr_r[m] = '0; wen_r[m] = 0; len_r[m] = '0; wdata_r[m] = '0;
            wait_cnt[m] = 0; ack_cnt[m] = 0; done_cnt[m] = 0; err_cnt[m] = 0; last_rdata[m] = '0;
        end

        // reset state
        repeat (3) @(negedge sys_clk);
        check("rst_phy_req", 64'(phy_req), 0);
        check("rst_phy_addr", phy_addr, 0);
        check("rst_m_out", {58'd0, ack_w | wnext_w | rvalid_w | done_w | err_w, 2'b00} | (rdata_w[0] | rdata_w[1]), 0);
        sys_rst_n = 1'b1;
        mon_en = 1;
        step(2);
        check("idle_phy_req", 64'(phy_req), 0);

        // tie after reset: M0 first, then M1; next tie M0 again
        ack_log.delete();
        fork
            run_txn(0, 32'h0000_0040, 1'b0, 4'd1, '0);
            run_txn(1, 32'h0000_0080, 1'b0, 4'd2, '0);
        join
        check("tie1_count", 64'(ack_log.size()), 2);
        if (ack_log.size() == 2) begin
            check("tie1_first", 64'(ack_log[0]), 0);
            check("tie1_second", 64'(ack_log[1]), 1);
        end
        ack_log.delete();
        fork
            run_txn(0, 32'h0000_00C0, 1'b0, 4'd0, '0);
            run_txn(1, 32'h0000_00C8, 1'b0, 4'd0, '0);
        join
        check("tie2_first", 64'(ack_log.size() > 0 ? ack_log[0] : -1), 0);

        // M0 single-beat read of a known word
        ext_mem[32'h20] = 64'hDEAD_BEEF;
        ref_mem[32'h20] = 64'hDEAD_BEEF;
        snap_a = ack_cnt[0]; snap_d = done_cnt[0];
        run_txn(0, 32'h0000_0100, 1'b0, 4'd0, '0);
        check("t1_acks", 64'(ack_cnt[0] - snap_a), 1);
        check("t1_dones", 64'(done_cnt[0] - snap_d), 1);
        check("t1_rdata", last_rdata[0], 64'hDEAD_BEEF);

        // M1 4-beat write
        d = {$urandom, $urandom};
        run_txn(1, 32'h0000_2000, 1'b1, 4'd3, d);
        for (int i = 0; i < 4; i++) check("t3_mem", ext_rd(32'h400 + i), d + 64'(i));

        // both masters streaming: grants alternate starting with M0
        ack_log.delete();
        fork
            for (int k = 0; k < 4; k++) run_txn(0, rnd_addr(), 1'b0, 4'($urandom_range(0, 5)), '0);
            for (int k = 0; k < 4; k++) run_txn(1, rnd_addr(), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 5)), {$urandom, $urandom});
        join
        check("alt_count", 64'(ack_log.size()), 8);
        for (int k = 0; k < ack_log.size(); k++) check("alt_order", 64'(ack_log[k]), 64'(k % 2));

        // randomized traffic with spurious PHY read strobes
        spur_en = 1;
        fork
            for (int k = 0; k < 25; k++) begin
                step($urandom_range(0, 3));
                run_txn(0, rnd_addr(), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), {$urandom, $urandom});
            end
            for (int k = 0; k < 25; k++) begin
                step($urandom_range(0, 3));
                run_txn(1, rnd_addr(), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), {$urandom, $urandom});
            end
        join
        spur_en = 0;
        check("rand_no_err", 64'(err_cnt[0] + err_cnt[1]), 0);
        step(4);

        // reset in the middle of an 8-beat read
        addr_r[0] = 32'h0000_0300; wen_r[0] = 0; len_r[0] = 4'd7; req_r[0] = 1'b1;
        n = 0;
        while (!ack_w[0] && n < 200) begin @(negedge sys_clk); n++; end
        check("rst_txn_ack", 64'(ack_w[0]), 1);
        @(posedge sys_clk); #1;
        req_r[0] = 1'b0;
        n = 0;
        while (!(busy && beats >= 2) && n < 200) begin @(negedge sys_clk); n++; end
        check("rst_txn_beats", 64'(beats >= 2), 1);
        sys_rst_n = 1'b0;
        busy = 0; exp_q.delete();
        snap_d = done_cnt[0];
        for (int i = 0; i < 3; i++) begin
            @(negedge sys_clk);
            check("rst_mid_phy_req", 64'(phy_req), 0);
            check("rst_mid_strobes", {60'd0, rvalid_w | done_w}, 0);
        end
        sys_rst_n = 1'b1;
        step(1);
        check("rst_mid_no_done", 64'(done_cnt[0] - snap_d), 0);
        snap_d = done_cnt[0];
        run_txn(0, 32'h0000_0108, 1'b0, 4'd0, '0);
        check("rst_after_done", 64'(done_cnt[0] - snap_d), 1);

        // PHY never returns data: watchdog abort, then a fresh grant works
        withhold = 1;
        snap_e = err_cnt[0];
        run_txn(0, 32'h0000_0400, 1'b0, 4'd2, '0);
        check("tmo_err", 64'(err_cnt[0] - snap_e), 1);
        @(negedge sys_clk);
        rd_q.delete();
        withhold = 0;
        step(1);
        check("tmo_phy_req_drop", 64'(phy_req), 0);
        snap_d = done_cnt[1];
        run_txn(1, 32'h0000_0408, 1'b0, 4'd0, '0);
        check("tmo_next_done", 64'(done_cnt[1] - snap_d), 1);

        step(4);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
